// File: rtl/soc_ram_dma_master.sv
// Fill/copy initiator for the single-port 16-bit data RAM. The CPU arbiter owns the port
// whenever ram_gnt=0, so every access strobe is qualified by the grant in the same cycle.
module soc_ram_dma_master #(
   parameter int ADDR_MSB = 6,
   parameter int LEN_MSB  = 6
) (
   input  logic              mclk,
   input  logic              reset_n,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic              cfg_mode,
   input  logic [ADDR_MSB:0] cfg_src,
   input  logic [ADDR_MSB:0] cfg_dst,
   input  logic [LEN_MSB:0]  cfg_len,
   input  logic [15:0]       cfg_pattern,
   output logic              busy,
   output logic              done,
   output logic [LEN_MSB:0]  words_left,
   input  logic              ram_gnt,
   output logic [ADDR_MSB:0] ram_addr,
   output logic              ram_cen,
   output logic [1:0]        ram_wen,
   output logic [15:0]       ram_din,
   input  logic [15:0]       ram_dout
);

   localparam int ADDR_W = ADDR_MSB + 1;
   localparam int LEN_W  = LEN_MSB + 1;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FIN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_MSB:0] r_src;
   logic [ADDR_MSB:0] r_dst;
   logic [LEN_MSB:0]  r_left;
   logic              r_mode;
   logic [15:0]       r_pat;
   logic [15:0]       r_data;
   logic              w_start;
   logic              w_wr_go;

   assign w_start = (r_state == S_IDLE) && cfg_start && !cfg_abort;
   assign w_wr_go = (r_state == S_WR) && ram_gnt && !cfg_abort;

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_next = (cfg_len == '0) ? S_FIN : (cfg_mode ? S_RD : S_WR);
         S_RD:   if (ram_gnt) w_next = S_CAP;
         S_CAP:  w_next = S_WR;
         S_WR:   if (ram_gnt) w_next = (r_left == LEN_W'(1)) ? S_FIN : (r_mode ? S_RD : S_WR);
         S_FIN:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (cfg_abort && r_state != S_IDLE) w_next = S_IDLE;
   end

   // words_left is left untouched on abort so software can see how far the transfer got
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_left <= '0;
         r_mode <= 1'b0;
         r_pat  <= '0;
         r_data <= '0;
      end else begin
         if (w_start) begin
            r_src  <= cfg_src;
            r_dst  <= cfg_dst;
            r_left <= cfg_len;
            r_mode <= cfg_mode;
            r_pat  <= cfg_pattern;
         end
         if (r_state == S_CAP) r_data <= ram_dout;
         if (w_wr_go) begin
            r_src  <= r_src + ADDR_W'(1);
            r_dst  <= r_dst + ADDR_W'(1);
            r_left <= r_left - LEN_W'(1);
         end
      end
   end

   always_comb begin
      busy     = (r_state != S_IDLE);
      done     = (r_state == S_FIN);
      ram_cen  = 1'b1;
      ram_wen  = 2'b11;
      ram_addr = '0;
      ram_din  = '0;
      case (r_state)
         S_RD: begin
            ram_addr = r_src;
            if (ram_gnt && !cfg_abort) ram_cen = 1'b0;
         end
         S_WR: begin
            ram_addr = r_dst;
            ram_din  = r_mode ? r_data : r_pat;
            if (ram_gnt && !cfg_abort) begin
               ram_cen = 1'b0;
               ram_wen = 2'b00;
            end
         end
         default: ;
      endcase
   end

   assign words_left = r_left;

endmodule
